// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake and operand/product bus for seq_multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH cycles, start/busy/done.
// Define SEQ_MUL_SIGNED_EN to honour signed_mode (sign-magnitude around the unsigned core).
module seq_multiplier #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_multiplier_if.slave   bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   step;
  logic                 last;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 sign_cap;

`ifdef SEQ_MUL_SIGNED_EN
  always_comb begin
    a_mag    = bus.a;
    b_mag    = bus.b;
    sign_cap = 1'b0;
    if (bus.signed_mode) begin
      if (bus.a[WIDTH-1]) a_mag = -bus.a;
      if (bus.b[WIDTH-1]) b_mag = -bus.b;
      sign_cap = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = bus.signed_mode;
  assign a_mag    = bus.a;
  assign b_mag    = bus.b;
  assign sign_cap = 1'b0;
`endif

  assign last = (cnt_q == CW'(WIDTH - 1));

  // Upper half holds the running sum, lower half the not-yet-consumed multiplier bits.
  always_comb begin
    sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    step = {sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CALC;
      S_CALC:  if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          mcand_d = a_mag;
          cnt_d   = '0;
          neg_d   = sign_cap;
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (last) prod_d = neg_q ? -step : step;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.product = prod_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboarded random/directed bench for seq_multiplier at WIDTH=16.
module tb_seq_multiplier;
  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] exp;
    int             e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  seq_multiplier_if #(.WIDTH(W)) bus();

  seq_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    longint          sa, sb;
    longint unsigned ua, ub;
`ifdef SEQ_MUL_SIGNED_EN
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return (2*W)'(sa * sb);
    end
`endif
    ua = longint'(a);
    ub = longint'(b);
    return (2*W)'(ua * ub);
  endfunction

  // Monitor: every done cycle must match the oldest outstanding request, WIDTH edges after accept.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(bus.done), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", 64'(bus.product), 64'(e.exp));
        check("done_latency", 64'(cyc - e.e0), 64'(W));
        check("busy_in_done", 64'(bus.busy), 64'(1));
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || sb_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(n), 64'(0));
  endtask

  // Drives one accepted start; returns the accept edge number.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       input logic [2*W-1:0] exp, output int e0);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 64'(n), 64'(0));
    bus.start       = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
    e0    = cyc + 1;
    e.exp = exp;
    e.e0  = e0;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start       = 1'b0;
    bus.a           = W'($urandom);
    bus.b           = W'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  initial begin
    int e0;
    logic [W-1:0] ra, rb;
    logic rs;

    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_product", 64'(bus.product), 64'(0));
    rst_n = 1'b1;

    // 3*5 with busy timing around the DONE cycle
    issue(16'd3, 16'd5, 1'b0, 32'h0000000F, e0);
    wait_cyc(e0 + W);
    check("busy_last_calc", 64'(bus.busy), 64'(1));
    wait_cyc(e0 + W + 1);
    check("busy_after_done", 64'(bus.busy), 64'(0));
    wait_idle();

    issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, e0);
    issue(16'h0000, 16'h1234, 1'b0, 32'h00000000, e0);
`ifdef SEQ_MUL_SIGNED_EN
    issue(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, e0);
    issue(16'h8000, 16'h8000, 1'b1, 32'h40000000, e0);
    issue(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, e0);
`else
    issue(16'hFFFF, 16'h0002, 1'b1, 32'h0001FFFE, e0);
    issue(16'h8000, 16'h8000, 1'b1, 32'h40000000, e0);
    issue(16'h8000, 16'h0001, 1'b1, 32'h00008000, e0);
`endif
    wait_idle();

    // Starts during CALC must be ignored
    issue(16'h00AB, 16'h0100, 1'b0, 32'h0000AB00, e0);
    wait_cyc(e0 + 4);
    bus.start = 1'b1; bus.a = 16'h7777; bus.b = 16'h3333;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(e0 + 15);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.signed_mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // start held high: restart at the first IDLE edge, W+2 apart
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0102; bus.b = 16'h0304; bus.signed_mode = 1'b0;
    e0 = cyc + 1;
    sb_q.push_back('{exp: 32'h0003_0A08, e0: e0});
    sb_q.push_back('{exp: 32'h0003_0A08, e0: e0 + W + 2});
    wait_cyc(e0 + W + 2);
    bus.start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-operation
    issue(16'h1234, 16'h5678, 1'b0, model(16'h1234, 16'h5678, 1'b0), e0);
    wait_cyc(e0 + 6);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_product", 64'(bus.product), 64'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, e0);
    wait_idle();

    // Random operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (i % 6 == 0) ra = (i % 12 == 0) ? 16'h8000 : 16'hFFFF;
      issue(ra, rb, rs, model(ra, rb, rs), e0);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
